wb_rx_interface: RTL and testbench

- Wishbone byte-wide slave for the Ethernet receive path.
- Pulls a received frame length from the RX-MAC clock domain via a 4-phase ready/ack handshake.
- Lets the host read payload bytes out of the RX FIFO, feeding each byte into a crc32 instance.
- Pops and checks the 4 trailing FCS bytes itself and reports frame-done and CRC status through a status register.

---
 rtl/wb_rx_interface.sv | 148 ++++++++++++++
 tb/tb_wb_rx_interface.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rx_interface.sv
// wb_rx_interface: Wishbone byte slave that reads RX frames, checks the trailing FCS and reports status.
module crc32 (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] crc_q, crc_d;
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 8; i++) crc_d = (crc_d >> 1) ^ ((crc_d[0] ^ data_i[i]) ? 32'hEDB88320 : 32'h0);
  end
  always_ff @(posedge clk) crc_q <= rst_i ? '1 : en_i ? crc_d : crc_q;
  assign crc_o = ~crc_q;
endmodule

module wb_rx_interface #(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [7:0]       i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [7:0]       o_wb_data,
  input  logic             i_fifo_empty,
  input  logic [7:0]       i_fifo_data,
  output logic             o_fifo_rd,
  input  logic [LEN_W-1:0] i_word_count,
  input  logic             word_count_ready,
  output logic             word_count_ack
);
  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_PAYLOAD, S_WAIT0, S_WAIT1,
    S_FCS0, S_FCS1, S_FCS2, S_FCS3, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, rem_q, rem_d;
  logic              err_q, err_d, wca_d;
  logic [2:0]        sync_q;
  logic              crc_rst_q, crc_en_q;
  logic [7:0]        crc_din_q, rdata, status, fcs_exp;
  logic [31:0]       crc_out;
  logic              rdy_s, acc, rd0, rel, fcs_st, done;
  logic              unused_wdata;

  assign unused_wdata = ^i_wb_data;
  assign rdy_s  = sync_q[2];
  assign o_wb_stall = i_wb_stb && !i_wb_we && i_wb_addr == 2'd0 &&
                      (state_q != S_PAYLOAD || i_fifo_empty || rem_q == '0);
  assign acc    = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign rd0    = acc && !i_wb_we && i_wb_addr == 2'd0;
  assign rel    = acc && i_wb_we && i_wb_addr == 2'd3;
  assign fcs_st = state_q inside {S_FCS0, S_FCS1, S_FCS2, S_FCS3};
  assign done   = state_q == S_DONE;
  assign status = {state_q == S_PAYLOAD, done, done && !err_q, 2'b00, 3'(len_q >> 8)};
  assign rdata  = i_wb_addr == 2'd0 ? i_fifo_data :
                  i_wb_addr == 2'd1 ? len_q[7:0] :
                  i_wb_addr == 2'd2 ? status : 8'h00;
  // FCS bytes arrive least-significant byte of the final CRC first
  assign fcs_exp = state_q == S_FCS0 ? crc_out[7:0] :
                   state_q == S_FCS1 ? crc_out[15:8] :
                   state_q == S_FCS2 ? crc_out[23:16] : crc_out[31:24];
  assign o_fifo_rd = rd0 || (fcs_st && !i_fifo_empty) ||
                     (state_q == S_DRAIN && !i_fifo_empty && rem_q != '0);

  crc32 u_crc (
    .clk    (clk),
    .rst_i  (!rst_n || crc_rst_q),
    .en_i   (crc_en_q),
    .data_i (crc_din_q),
    .crc_o  (crc_out)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    err_d   = err_q;
    wca_d   = word_count_ack && rdy_s;
    case (state_q)
      S_IDLE: if (rdy_s && !word_count_ack) begin
        len_d   = i_word_count;
        wca_d   = 1'b1;
        err_d   = 1'b0;
        state_d = S_LEN;
      end
      S_LEN: if (len_q < LEN_W'(4)) begin
        err_d   = 1'b1;
        rem_d   = len_q;
        state_d = S_DRAIN;
      end else begin
        rem_d   = len_q - LEN_W'(4);
        state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (rel) begin
        rem_d   = rem_q + LEN_W'(4);
        err_d   = 1'b1;
        state_d = S_DRAIN;
      end else if (rem_q == '0) state_d = S_WAIT0;
      else if (rd0) rem_d = rem_q - LEN_W'(1);
      S_WAIT0: state_d = S_WAIT1;
      S_WAIT1: state_d = S_FCS0;
      S_FCS0, S_FCS1, S_FCS2, S_FCS3: if (!i_fifo_empty) begin
        err_d   = err_q || i_fifo_data != fcs_exp;
        state_d = state_q == S_FCS3 ? S_DONE : state_t'(state_q + 4'd1);
      end
      S_DRAIN: if (rem_q == '0) state_d = S_DONE;
      else if (!i_fifo_empty) rem_d = rem_q - LEN_W'(1);
      S_DONE: if (rel) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      rem_q          <= '0;
      err_q          <= 1'b0;
      word_count_ack <= 1'b0;
      sync_q         <= '0;
      crc_rst_q      <= 1'b0;
      crc_en_q       <= 1'b0;
      crc_din_q      <= '0;
      o_wb_ack       <= 1'b0;
      o_wb_data      <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      rem_q          <= rem_d;
      err_q          <= err_d;
      word_count_ack <= wca_d;
      sync_q         <= {sync_q[1:0], word_count_ready};
      crc_rst_q      <= state_d == S_IDLE;
      crc_en_q       <= rd0;
      crc_din_q      <= rd0 ? i_fifo_data : crc_din_q;
      o_wb_ack       <= acc;
      o_wb_data      <= acc ? rdata : o_wb_data;
    end
  end
endmodule

// File: tb/tb_wb_rx_interface.sv
// tb_wb_rx_interface: directed frames through a modelled RX FIFO with hand-derived status values.
module tb_wb_rx_interface;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [1:0] wb_addr = 0;
  logic [7:0] wb_wdata = 0;
  logic wb_ack, wb_stall, fifo_empty, fifo_rd, wc_ack;
  logic [7:0] wb_rdata, fifo_data;
  logic [10:0] word_count = 0;
  logic wc_ready = 0;

  logic [7:0] fmem [0:4095];
  logic [7:0] exp_pay [0:2047];
  int wr = 0, rd = 0, checks = 0, fails = 0;

  assign fifo_empty = rd == wr;
  assign fifo_data  = fmem[rd[11:0]];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd <= wr;
    else if (fifo_rd && rd != wr) rd <= rd + 1;

  wb_rx_interface dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
    .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata),
    .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data), .o_fifo_rd(fifo_rd),
    .i_word_count(word_count), .word_count_ready(wc_ready), .word_count_ack(wc_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  task automatic push(input logic [7:0] b);
    fmem[wr[11:0]] = b;
    wr++;
  endtask

  task automatic push_frame(input int n, input bit bad);
    logic [31:0] c;
    logic [7:0] fb;
    c = '1;
    for (int i = 0; i < n; i++) begin
      push(exp_pay[i]);
      c = crc_upd(c, exp_pay[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      fb = 8'(c >> (8 * k));
      if (bad && k == 3) fb = fb ^ 8'h80;
      push(fb);
    end
  endtask

  task automatic wb_read(input logic [1:0] a, input int limit, output logic [7:0] d, output logic ok);
    int n = 0;
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = a;
    #1;
    while (wb_stall && n < limit) begin
      @(negedge clk); #1; n++;
    end
    if (wb_stall) begin
      wb_stb = 0; wb_cyc = 0; d = 0; ok = 0;
    end else begin
      @(posedge clk); #1;
      wb_stb = 0; wb_cyc = 0;
      ok = wb_ack; d = wb_rdata;
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = a; wb_wdata = v;
    @(posedge clk); #1;
    wb_stb = 0; wb_cyc = 0; wb_we = 0;
  endtask

  task automatic start_frame(input logic [10:0] len, input bit hold);
    int n = 0;
    word_count = len;
    wc_ready = 1;
    while (!wc_ack && n < 20) begin @(negedge clk); n++; end
    check("wc_ack_set", wc_ack, 1);
    if (!hold) begin
      wc_ready = 0;
      n = 0;
      while (wc_ack && n < 20) begin @(negedge clk); n++; end
      check("wc_ack_clr", wc_ack, 0);
    end
  endtask

  task automatic wait_done();
    logic [7:0] d;
    logic ok;
    for (int i = 0; i < 200; i++) begin
      wb_read(2, 5, d, ok);
      if (d[6]) break;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic ok;
    logic [31:0] c;
    int errs;
    repeat (2) @(negedge clk);
    check("rst_ack", wb_ack, 0);
    check("rst_data", wb_rdata, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_wc_ack", wc_ack, 0);
    rst_n = 1;

    exp_pay[0] = 8'h11; exp_pay[1] = 8'h22; exp_pay[2] = 8'h33; exp_pay[3] = 8'h44;
    push_frame(4, 0);
    start_frame(8, 0);
    for (int i = 0; i < 4; i++) begin
      wb_read(0, 20, d, ok);
      check("t1_ack", ok, 1);
      check("t1_byte", d, exp_pay[i]);
    end
    wait_done();
    wb_read(2, 5, d, ok);
    check("t1_status", d, 8'h60);
    check("t1_fifo_empty", fifo_empty, 1);
    wb_write(3, 8'h5C);
    wb_read(2, 5, d, ok);
    check("t1_idle_status", d, 8'h00);

    push_frame(4, 1);
    start_frame(8, 0);
    for (int i = 0; i < 4; i++) wb_read(0, 20, d, ok);
    check("t2_last_byte", d, 8'h44);
    wait_done();
    wb_read(2, 5, d, ok);
    check("t2_status", d, 8'h40);
    check("t2_fifo_empty", fifo_empty, 1);
    wb_write(3, 8'h00);

    push(8'hAA); push(8'hBB);
    start_frame(2, 0);
    wb_read(0, 5, d, ok);
    check("t3_stalled", ok, 0);
    wait_done();
    wb_read(2, 5, d, ok);
    check("t3_status", d, 8'h40);
    check("t3_fifo_empty", fifo_empty, 1);
    wb_write(3, 8'h00);

    for (int i = 0; i < 1025; i++) exp_pay[i] = 8'(i * 7 + 3);
    push_frame(1025, 0);
    start_frame(11'h405, 0);
    wb_read(1, 5, d, ok);
    check("t4_len_lo", d, 8'h05);
    wb_read(2, 5, d, ok);
    check("t4_status_avail", d, 8'h84);
    errs = 0;
    for (int i = 0; i < 1025; i++) begin
      wb_read(0, 20, d, ok);
      if (!ok || d !== exp_pay[i]) errs++;
    end
    check("t4_payload_errs", errs, 0);
    wait_done();
    wb_read(2, 5, d, ok);
    check("t4_status", d, 8'h64);
    wb_write(3, 8'h00);

    for (int i = 0; i < 6; i++) exp_pay[i] = 8'(8'hC0 + i);
    push_frame(6, 0);
    start_frame(10, 1);
    wb_read(0, 20, d, ok);
    check("t5_byte0", d, 8'hC0);
    wb_write(3, 8'hFF);
    wait_done();
    wb_read(2, 5, d, ok);
    check("t5_status", d, 8'h40);
    check("t5_fifo_empty", fifo_empty, 1);
    wb_write(3, 8'h00);
    word_count = 6;
    repeat (8) @(negedge clk);
    wb_read(2, 5, d, ok);
    check("t5_no_recapture", d, 8'h00);
    wc_ready = 0;
    for (int i = 0; i < 20 && wc_ack; i++) @(negedge clk);
    check("t5_ack_drop", wc_ack, 0);
    start_frame(6, 1);
    wc_ready = 0;
    wb_read(2, 5, d, ok);
    check("t5_new_avail", d, 8'h80);

    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = 0;
    repeat (3) @(negedge clk);
    #1;
    check("t6_stall", wb_stall, 1);
    check("t6_no_ack", wb_ack, 0);
    push(8'hA5);
    #1;
    check("t6_unstall", wb_stall, 0);
    @(posedge clk); #1;
    wb_stb = 0; wb_cyc = 0;
    check("t6_ack", wb_ack, 1);
    check("t6_byte", wb_rdata, 8'hA5);
    push(8'h5A);
    wb_read(0, 20, d, ok);
    check("t6_byte2", d, 8'h5A);
    c = ~crc_upd(crc_upd('1, 8'hA5), 8'h5A);
    push(c[7:0]);
    repeat (8) @(negedge clk);
    check("t6_fcs0_popped", fifo_empty, 1);
    #2 rst_n = 0;
    #1;
    check("t6_rst_ack", wb_ack, 0);
    check("t6_rst_data", wb_rdata, 0);
    check("t6_rst_fifo_rd", fifo_rd, 0);
    check("t6_rst_wc_ack", wc_ack, 0);
    check("t6_rst_stall", wb_stall, 0);
    @(negedge clk);
    rst_n = 1;
    wb_read(2, 5, d, ok);
    check("t6_post_rst_status", d, 8'h00);
    wb_read(1, 5, d, ok);
    check("t6_post_rst_len", d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
